// File: rtl/qkv_skew_feeder_pkg.sv
// Shared accelerator definitions: feeder FSM encoding, lane derivation and a
// constant-foldable clog2 for sizing pointers and counters.
package bert_accel_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2,
        FEED_DONE   = 2'd3
    } feed_state_e;

    function automatic int clog2(input int value);
        int res;
        int pow;
        res = 0;
        pow = 1;
        while (pow < value) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int lanes_of(input int data_width, input int num_bits);
        return data_width / num_bits;
    endfunction

endpackage

// File: rtl/qkv_skew_feeder_fifo.sv
// Synchronous FIFO with occupancy count. A push at full is accepted only when
// a pop in the same cycle frees the slot; otherwise it is ignored.
module sync_fifo
    import bert_accel_pkg::*;
#(
    parameter int WIDTH = 257,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [WIDTH-1:0] wdata,
    input  logic            pop,
    output logic [WIDTH-1:0] rdata,
    output logic            full,
    output logic            empty,
    output logic [AW:0]     count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qkv_skew_feeder.sv
// Buffers fetched Q/K/V words and feeds them diagonally skewed into the
// systolic array rows; lane k trails lane 0 by k advancing cycles.
module qkv_skew_feeder
    import bert_accel_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int NUM_BITS     = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 2,
    localparam int LANES       = lanes_of(DATA_WIDTH, NUM_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] lane_data,
    output logic [LANES-1:0]      lane_valid,
    output logic                  busy,
    output logic                  feed_done,
    output logic                  overflow_err
);

    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam int DW = (clog2(LANES) < 1) ? 1 : clog2(LANES);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [DW-1:0] DRAIN_INIT  = DW'(LANES - 1);

    feed_state_e         state;
    feed_state_e         state_nxt;
    logic [DW-1:0]       drain_cnt;
    logic                adv;
    logic                pop;
    logic                pop_last;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [DATA_WIDTH:0] fifo_rdata;

    assign adv      = out_ready;
    assign pop_last = fifo_rdata[DATA_WIDTH];
    assign in_ready = (fifo_count < AFULL_LEVEL);

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({in_last, in_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FEED_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FEED_IDLE:   if (in_valid || !fifo_empty) state_nxt = FEED_STREAM;
            FEED_STREAM: if (pop && pop_last)         state_nxt = FEED_DRAIN;
            FEED_DRAIN:  if (adv && drain_cnt == '0)  state_nxt = FEED_DONE;
            FEED_DONE:                                state_nxt = FEED_IDLE;
            default:                                  state_nxt = FEED_IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        busy      = 1'b0;
        feed_done = 1'b0;
        pop       = adv & ~fifo_empty & (state == FEED_STREAM);
        busy      = (state != FEED_IDLE);
        feed_done = (state == FEED_DONE);
    end

    // Drain needs one advance per trailing lane plus the final one that
    // shifts the last element out of lane LANES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (pop && pop_last) begin
            drain_cnt <= DRAIN_INIT;
        end else if (state == FEED_DRAIN && adv && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (in_valid && fifo_full && !pop) begin
            overflow_err <= 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : gen_lane
        logic [NUM_BITS:0] stage [0:k];
        logic [NUM_BITS:0] head;

        assign head = pop ? {1'b1, fifo_rdata[k*NUM_BITS +: NUM_BITS]} : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= k; i++) stage[i] <= '0;
            end else if (adv) begin
                stage[0] <= head;
                for (int i = 1; i <= k; i++) stage[i] <= stage[i-1];
            end
        end

        assign lane_data[k*NUM_BITS +: NUM_BITS] = stage[k][NUM_BITS-1:0];
        assign lane_valid[k]                     = stage[k][NUM_BITS];
    end

endmodule

// File: tb/tb_qkv_skew_feeder.sv
// Bench for qkv_skew_feeder: per-lane expected queues filled at push time and
// drained as skewed elements appear, plus directed timing and status checks.
module tb_qkv_skew_feeder;

    localparam int DATA_WIDTH = 256;
    localparam int NUM_BITS   = 8;
    localparam int LANES      = DATA_WIDTH / NUM_BITS;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [DATA_WIDTH-1:0] in_data = '0;
    logic                  in_last = 1'b0;
    logic                  in_ready;
    logic                  out_ready = 1'b1;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [LANES-1:0]      lane_valid;
    logic                  busy;
    logic                  feed_done;
    logic                  overflow_err;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    logic [NUM_BITS-1:0]   exp_q [LANES][$];
    logic                  adv_q = 1'b0;
    logic                  rst_q = 1'b1;
    logic [DATA_WIDTH-1:0] prev_data = '0;
    logic [LANES-1:0]      prev_valid = '0;

    always #5 clk = ~clk;

    qkv_skew_feeder #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_BITS     (NUM_BITS),
        .FIFO_DEPTH   (8),
        .AFULL_MARGIN (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .busy         (busy),
        .feed_done    (feed_done),
        .overflow_err (overflow_err)
    );

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                         input logic [DATA_WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remember whether the last edge advanced the pipeline or reset it.
    always @(posedge clk) begin
        adv_q = out_ready;
        rst_q = rst;
    end

    // Scoreboard: each advance presents new lane contents; a stall must hold them.
    always @(negedge clk) begin
        if (!rst_q) begin
            if (adv_q) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_valid[k]) begin
                        if (exp_q[k].size() == 0) check($sformatf("lane%0d_extra", k), 1, 0);
                        else check($sformatf("lane%0d_data", k), lane_data[k*NUM_BITS +: NUM_BITS],
                                   exp_q[k].pop_front());
                    end else begin
                        check($sformatf("lane%0d_bubble", k), lane_data[k*NUM_BITS +: NUM_BITS], 0);
                    end
                end
            end else begin
                check("frozen_data", lane_data, prev_data);
                check("frozen_valid", lane_valid, prev_valid);
            end
            if (feed_done) fd_count++;
        end
        prev_data  = lane_data;
        prev_valid = lane_valid;
    end

    task automatic clear_queues();
        for (int k = 0; k < LANES; k++) exp_q[k].delete();
    endtask

    function automatic int queued_total();
        int n;
        n = 0;
        for (int k = 0; k < LANES; k++) n += exp_q[k].size();
        return n;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        @(negedge clk);
        clear_queues();
        repeat (cycles - 1) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push_word(input logic [DATA_WIDTH-1:0] d, input logic last);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            out_ready = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < LANES; k++) exp_q[k].push_back(d[k*NUM_BITS +: NUM_BITS]);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (!feed_done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("feed_done_seen", feed_done, 1);
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] d;
        logic [LANES-1:0]      one_hot;
        logic [LANES-1:0]      lv_exp;
        logic [NUM_BITS-1:0]   b;
        int fd0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lane_valid", lane_valid, 0);
        check("rst_lane_data", lane_data, 0);
        check("rst_busy", busy, 0);
        check("rst_feed_done", feed_done, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_overflow", overflow_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single word: lane k valid only at push+2+k, feed_done one cycle after lane 31
        for (int k = 0; k < LANES; k++) d[k*NUM_BITS +: NUM_BITS] = NUM_BITS'(k);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = 1'b1;
        for (int k = 0; k < LANES; k++) exp_q[k].push_back(d[k*NUM_BITS +: NUM_BITS]);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        one_hot  = 1;
        for (int n = 1; n <= 36; n++) begin
            lv_exp = (n >= 2 && n <= LANES + 1) ? (one_hot << (n - 2)) : '0;
            check($sformatf("single_valid_c%0d", n), lane_valid, lv_exp);
            check($sformatf("single_done_c%0d", n), feed_done, (n == LANES + 2));
            @(negedge clk);
        end
        check("single_idle", busy, 0);
        check("single_drained", queued_total(), 0);

        // Burst of four constant-byte words
        fd0 = fd_count;
        for (int i = 0; i < 4; i++) begin
            b = NUM_BITS'(2 * (i + 1));
            d = {LANES{b}};
            push_word(d, i == 3);
        end
        wait_done(200);
        @(negedge clk);
        check("burst_busy_fall", busy, 0);
        check("burst_one_done", fd_count, fd0 + 1);
        check("burst_drained", queued_total(), 0);

        // Backpressure: six stalled cycles while the FIFO fills
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word({8{$urandom()}}, 1'b0);
        check("bp_ready_cnt5", in_ready, 1);
        push_word({8{$urandom()}}, 1'b0);
        check("bp_ready_cnt6", in_ready, 0);
        out_ready = 1'b1;
        push_word({8{$urandom()}}, 1'b0);
        push_word({8{$urandom()}}, 1'b1);
        wait_done(200);
        @(negedge clk);
        check("bp_overflow", overflow_err, 0);
        check("bp_drained", queued_total(), 0);

        // Random words with random stalls and gaps
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            out_ready = 1'($urandom_range(0, 1));
            push_word({8{$urandom()}}, i == 11);
        end
        out_ready = 1'b1;
        wait_done(300);
        @(negedge clk);
        check("rand_drained", queued_total(), 0);

        // Reset ten cycles into drain
        fd0 = fd_count;
        push_word({8{$urandom()}}, 1'b1);
        repeat (11) @(negedge clk);
        check("mid_drain_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        clear_queues();
        check("mid_rst_valid", lane_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_done", feed_done, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", fd_count, fd0);
        check("mid_rst_idle", busy, 0);

        // Overflow: nine pushes into a stalled FIFO, ninth dropped
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("ovf_before", overflow_err, 0);
            d = {8{$urandom()}};
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (i == 7);
            if (i < 8) for (int k = 0; k < LANES; k++) exp_q[k].push_back(d[k*NUM_BITS +: NUM_BITS]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("ovf_set", overflow_err, 1);
        out_ready = 1'b1;
        wait_done(200);
        @(negedge clk);
        check("ovf_sticky", overflow_err, 1);
        check("ovf_drained", queued_total(), 0);
        do_reset(2);
        check("ovf_cleared", overflow_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
